instr_fetch_sched: RTL and testbench
====================================

INSTR_FETCH_SCHED -- requirements
Module: instr_fetch_sched

Interface
REQ-001 SHALL have parameter CHUNK_BYTES, default 4096, power of two, max bytes per fetch command.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, range 1..15, max issued commands awaiting status.
REQ-003 SHALL have ports (clock and reset first):
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  global advance enable.
- ap_start  in  1  run request, level, held until ap_done.
- instr_base_addr  in  64  byte address of the instruction stream.
- instr_btt  in  32  instruction stream length in bytes.
- ap_done  out  1  one-cycle run-complete pulse.
- ap_idle  out  1  high in IDLE.
- ap_ready  out  1  one-cycle pulse when a run is accepted.
- cmd_valid / cmd_ready  out / in  1 / 1  fetch command handshake.
- cmd_addr  out  64  command byte address.
- cmd_btt  out  23  command byte count.
- cmd_eof  out  1  last command of the run.
- sts_valid / sts_ready  in / out  1 / 1  completion status handshake.
- sts_okay  in  1  1 = command succeeded.
- core_start  out  1  one-cycle pulse that starts instruction execution.
- core_done  in  1  one-cycle pulse when execution finishes.
- core_latency_cycles  out  32  cycles of the last or current run.
- core_instr_status  out  32  {chunks_issued[15:0], 3'b0, err, outstanding[3:0], 5'b0, state[2:0]}.

Function
REQ-004 SHALL use states IDLE, FETCH, DRAIN, RUN, DONE, ERR.
REQ-005 SHALL register nothing and change no state in any cycle with clk_en low; the handshakes complete only when clk_en is high.
REQ-006 IDLE, with ap_start high: SHALL latch instr_base_addr and instr_btt, pulse ap_ready, and go to FETCH, or to RUN if instr_btt == 0.
REQ-007 FETCH: SHALL assert cmd_valid while outstanding < MAX_OUTSTANDING and bytes remain; cmd_btt = min(remaining, CHUNK_BYTES).
REQ-008 Command fields SHALL stay stable while cmd_valid is high and cmd_ready is low.
REQ-009 On each cmd handshake: address += CHUNK_BYTES, remaining -= cmd_btt, outstanding += 1, chunks_issued += 1 (saturating at 16'hFFFF); address wraps modulo 2^64.
REQ-010 cmd_eof SHALL be 1 exactly when remaining <= CHUNK_BYTES.
REQ-011 sts_ready SHALL be tied high in every state except IDLE; each sts handshake decrements outstanding.
REQ-012 Simultaneous cmd and sts handshakes SHALL leave outstanding unchanged.
REQ-013 FETCH SHALL go to DRAIN once remaining reaches 0.
REQ-014 DRAIN SHALL go to RUN when outstanding reaches 0 with err clear.
REQ-015 Any sts handshake with sts_okay == 0 SHALL set err; no further commands are then issued; the block drains outstanding statuses and goes to ERR.
REQ-016 RUN: SHALL pulse core_start on the first cycle, then wait for core_done; core_done in the core_start cycle SHALL be honoured.
REQ-017 On core_done, SHALL go to DONE.
REQ-018 DONE and ERR: SHALL pulse ap_done for one cycle and return to IDLE the next cycle; err remains readable until the next accept.
REQ-019 ap_start high on the cycle after DONE or ERR (auto-restart) SHALL start a new run normally.
REQ-020 core_done outside RUN SHALL be ignored.
REQ-021 A sts handshake with outstanding == 0 SHALL be ignored and SHALL NOT underflow.
REQ-022 Latency counter SHALL clear at accept, increment each enabled cycle until ap_done inclusive, saturate at 32'hFFFF_FFFF, and hold until the next accept.

Reset
REQ-023 rst high at a clock edge SHALL, regardless of clk_en, force state to IDLE, clear all counters, err, outputs and latched fields, and deassert cmd_valid, core_start, ap_done and ap_ready.
REQ-024 After reset: ap_idle = 1 and sts_ready = 0.
REQ-025 Reset mid-run SHALL abandon the run; later late statuses are ignored by REQ-011.

Configuration
REQ-026 Macro INSTR_FETCH_LATENCY_EN defined: the REQ-022 counter SHALL be built.
REQ-027 Macro INSTR_FETCH_LATENCY_EN undefined: core_latency_cycles SHALL be constant 0 and no counter logic SHALL be built.

Structure
REQ-028 Package instr_fetch_pkg SHALL hold the state encoding, the status bit-field positions and the 23-bit BTT width constant.
REQ-029 One sub-module, fetch_chunk_gen, SHALL hold the address, remaining, cmd_btt and cmd_eof generation.

Verification
REQ-030 Bench SHALL cover these five scenarios:
- base=0x1000, btt=10000, CHUNK 4096, all ok -> commands (0x1000,4096,0), (0x2000,4096,0), (0x3000,1808,1); core_start once; ap_done once.
- btt=0 -> no cmd_valid; core_start the cycle after ap_ready.
- MAX_OUTSTANDING=2, sts withheld, btt=16384 -> exactly 2 commands pending; the third is issued the cycle after the first sts.
- Second sts has sts_okay=0 while btt=16384 -> no further commands; drain; ap_done with err=1; no core_start.
- rst asserted during RUN, then ap_start -> clean restart with latency counting from 0; clk_en toggling stalls every counter and handshake.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch scheduler:
// state encoding, status word layout and command byte-count width.
package instr_fetch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_DRAIN = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5
   } state_e;

   localparam int BTT_W          = 23;
   localparam int STS_STATE_LSB  = 0;
   localparam int STS_OUTST_LSB  = 8;
   localparam int STS_ERR_BIT    = 12;
   localparam int STS_CHUNKS_LSB = 16;

   function automatic logic [31:0] pack_status(input logic [15:0] chunks,
                                                input logic        err,
                                                input logic [3:0]  outst,
                                                input state_e      st);
      logic [31:0] s;
      s = '0;
      s[STS_CHUNKS_LSB +: 16] = chunks;
      s[STS_ERR_BIT]          = err;
      s[STS_OUTST_LSB +: 4]   = outst;
      s[STS_STATE_LSB +: 3]   = st;
      return s;
   endfunction

endpackage

// File: rtl/instr_fetch_sched_if.sv
// Fetch command / completion status handshake bundle.
// master = scheduler side, slave = fetch engine side.
interface instr_fetch_sched_if;

   logic                              cmd_valid;
   logic                              cmd_ready;
   logic [63:0]                       cmd_addr;
   logic [instr_fetch_pkg::BTT_W-1:0] cmd_btt;
   logic                              cmd_eof;
   logic                              sts_valid;
   logic                              sts_ready;
   logic                              sts_okay;

   modport master (
      output cmd_valid, cmd_addr, cmd_btt, cmd_eof, sts_ready,
      input  cmd_ready, sts_valid, sts_okay
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_btt, cmd_eof, sts_ready,
      output cmd_ready, sts_valid, sts_okay
   );

endinterface

// File: rtl/fetch_chunk_gen.sv
// Splits the latched instruction stream into CHUNK_BYTES commands:
// tracks current address and remaining bytes, derives cmd_btt / cmd_eof.
module fetch_chunk_gen
   import instr_fetch_pkg::*;
#(
   parameter int CHUNK_BYTES = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_en,
   input  logic             load,
   input  logic [63:0]      base_addr,
   input  logic [31:0]      btt,
   input  logic             advance,
   output logic [63:0]      cmd_addr,
   output logic [BTT_W-1:0] cmd_btt,
   output logic             cmd_eof,
   output logic             rem_zero
);

   localparam logic [31:0] CHUNK_W = 32'(CHUNK_BYTES);
   localparam logic [63:0] CHUNK_A = 64'(CHUNK_BYTES);

   logic [63:0] addr_q, addr_d;
   logic [31:0] rem_q, rem_d;

   // Fields come straight from flops, so they only move on a handshake.
   assign cmd_addr = addr_q;
   assign cmd_btt  = (rem_q < CHUNK_W) ? rem_q[BTT_W-1:0] : CHUNK_W[BTT_W-1:0];
   assign cmd_eof  = (rem_q <= CHUNK_W);
   assign rem_zero = (rem_q == '0);

   always_comb begin
      addr_d = addr_q;
      rem_d  = rem_q;
      if (load) begin
         addr_d = base_addr;
         rem_d  = btt;
      end else if (advance) begin
         addr_d = addr_q + CHUNK_A;
         rem_d  = rem_q - 32'(cmd_btt);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         rem_q  <= '0;
      end else if (clk_en) begin
         addr_q <= addr_d;
         rem_q  <= rem_d;
      end
   end

endmodule

// File: rtl/instr_fetch_sched.sv
// Instruction fetch scheduler: fetches the stream in chunks, then starts the core.
// Optional latency counter is built only with INSTR_FETCH_LATENCY_EN defined.
//
// state | meaning
// IDLE  | waiting for ap_start, sts_ready low
// FETCH | issuing chunk commands, bounded by MAX_OUTSTANDING
// DRAIN | all commands issued (or error), waiting for outstanding statuses
// RUN   | core_start pulsed on entry, waiting for core_done
// DONE  | ap_done pulse after a good run
// ERR   | ap_done pulse after a failed fetch
module instr_fetch_sched
   import instr_fetch_pkg::*;
#(
   parameter int CHUNK_BYTES     = 4096,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clk_en,
   input  logic                       ap_start,
   input  logic [63:0]                instr_base_addr,
   input  logic [31:0]                instr_btt,
   output logic                       ap_done,
   output logic                       ap_idle,
   output logic                       ap_ready,
   instr_fetch_sched_if.master        fetch_bus,
   output logic                       core_start,
   input  logic                       core_done,
   output logic [31:0]                core_latency_cycles,
   output logic [31:0]                core_instr_status
);

   localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

   state_e      state_q, state_d;
   logic [3:0]  outst_q, outst_d;
   logic [15:0] chunks_q, chunks_d;
   logic        err_q, err_d;
   logic        started_q, started_d;

   logic accept;
   logic cmd_hs;
   logic sts_take;
   logic rem_zero;

   assign accept = (state_q == ST_IDLE) && ap_start;

   assign fetch_bus.cmd_valid = (state_q == ST_FETCH) && !err_q && !rem_zero
                                && (outst_q < MAX_OUT);
   assign fetch_bus.sts_ready = (state_q != ST_IDLE);

   assign cmd_hs   = fetch_bus.cmd_valid && fetch_bus.cmd_ready;
   // Statuses with nothing outstanding are stale (e.g. from before a reset).
   assign sts_take = fetch_bus.sts_valid && fetch_bus.sts_ready && (outst_q != '0);

   assign ap_ready   = accept && clk_en && !rst;
   assign ap_idle    = (state_q == ST_IDLE);
   assign ap_done    = (state_q == ST_DONE) || (state_q == ST_ERR);
   assign core_start = (state_q == ST_RUN) && !started_q;

   assign core_instr_status = pack_status(chunks_q, err_q, outst_q, state_q);

   fetch_chunk_gen #(.CHUNK_BYTES(CHUNK_BYTES)) u_chunk_gen (
      .clk       (clk),
      .rst       (rst),
      .clk_en    (clk_en),
      .load      (accept),
      .base_addr (instr_base_addr),
      .btt       (instr_btt),
      .advance   (cmd_hs),
      .cmd_addr  (fetch_bus.cmd_addr),
      .cmd_btt   (fetch_bus.cmd_btt),
      .cmd_eof   (fetch_bus.cmd_eof),
      .rem_zero  (rem_zero)
   );

   always_comb begin
      state_d   = state_q;
      outst_d   = outst_q;
      chunks_d  = chunks_q;
      err_d     = err_q;
      started_d = (state_q == ST_RUN);

      if (cmd_hs && !sts_take)
         outst_d = outst_q + 4'd1;
      else if (sts_take && !cmd_hs)
         outst_d = outst_q - 4'd1;

      if (cmd_hs && (chunks_q != 16'hFFFF))
         chunks_d = chunks_q + 16'd1;

      if (sts_take && !fetch_bus.sts_okay)
         err_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (ap_start) begin
               outst_d  = '0;
               chunks_d = '0;
               err_d    = 1'b0;
               state_d  = (instr_btt == '0) ? ST_RUN : ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (err_q || rem_zero)
               state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (outst_q == '0)
               state_d = err_q ? ST_ERR : ST_RUN;
         end
         ST_RUN: begin
            if (core_done)
               state_d = ST_DONE;
         end
         ST_DONE, ST_ERR: state_d = ST_IDLE;
         default:         state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         outst_q   <= '0;
         chunks_q  <= '0;
         err_q     <= 1'b0;
         started_q <= 1'b0;
      end else if (clk_en) begin
         state_q   <= state_d;
         outst_q   <= outst_d;
         chunks_q  <= chunks_d;
         err_q     <= err_d;
         started_q <= started_d;
      end
   end

`ifdef INSTR_FETCH_LATENCY_EN
   logic [31:0] lat_q, lat_d;

   // Counts every enabled cycle after accept up to and including ap_done.
   always_comb begin
      lat_d = lat_q;
      if (state_q == ST_IDLE) begin
         if (ap_start)
            lat_d = '0;
      end else if (lat_q != 32'hFFFF_FFFF) begin
         lat_d = lat_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         lat_q <= '0;
      else if (clk_en)
         lat_q <= lat_d;
   end

   assign core_latency_cycles = lat_q;
`else
   assign core_latency_cycles = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_sched.sv
// Directed bench for instr_fetch_sched (CHUNK 4096, MAX_OUTSTANDING 2).
// Expected latency values depend on INSTR_FETCH_LATENCY_EN.
module tb_instr_fetch_sched;

`ifdef INSTR_FETCH_LATENCY_EN
   localparam bit LAT_EN = 1'b1;
`else
   localparam bit LAT_EN = 1'b0;
`endif

   typedef struct packed {
      logic [63:0] a;
      logic [22:0] b;
      logic        e;
   } cmd_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_en;
   logic        ap_start;
   logic [63:0] base;
   logic [31:0] btt;
   logic        core_done;
   logic        ap_done, ap_idle, ap_ready, core_start;
   logic [31:0] lat, status;

   instr_fetch_sched_if bus ();

   instr_fetch_sched #(.CHUNK_BYTES(4096), .MAX_OUTSTANDING(2)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .clk_en              (clk_en),
      .ap_start            (ap_start),
      .instr_base_addr     (base),
      .instr_btt           (btt),
      .ap_done             (ap_done),
      .ap_idle             (ap_idle),
      .ap_ready            (ap_ready),
      .fetch_bus           (bus),
      .core_start          (core_start),
      .core_done           (core_done),
      .core_latency_cycles (lat),
      .core_instr_status   (status)
   );

   always #5 clk = ~clk;

   int   n_chk = 0, n_err = 0;
   cmd_t cmd_q[$];
   int   pend, credits, sts_idx, bad_idx, n_cmd_at_err;
   int   n_cs, n_done, n_rdy, n_cv;
   logic [2:0] last_st;
   bit   core_auto, cs_flag, en_toggle;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_counts();
      cmd_q.delete();
      pend = 0; sts_idx = 0; n_cmd_at_err = -1;
      n_cs = 0; n_done = 0; n_rdy = 0; n_cv = 0; cs_flag = 0;
   endtask

   // One clock: sample at negedge, then drive responders at posedge+1.
   task automatic step();
      @(negedge clk);
      if (rst) begin
         pend = 0;
      end else if (clk_en) begin
         if (bus.cmd_valid) n_cv++;
         if (bus.cmd_valid && bus.cmd_ready) begin
            cmd_q.push_back('{bus.cmd_addr, bus.cmd_btt, bus.cmd_eof});
            pend++;
         end
         if (bus.sts_valid && bus.sts_ready) begin
            if (pend > 0) pend--;
            credits--;
            if (!bus.sts_okay) n_cmd_at_err = cmd_q.size();
            sts_idx++;
         end
         if (core_done) cs_flag = 0;
         if (core_start) begin n_cs++; cs_flag = 1; end
         if (ap_done) begin n_done++; last_st = status[2:0]; end
         if (ap_ready) n_rdy++;
      end
      @(posedge clk); #1;
      if (en_toggle) clk_en = ~clk_en;
      bus.sts_valid = (pend > 0) && (credits > 0);
      bus.sts_okay  = (sts_idx != bad_idx);
      if (core_auto) core_done = cs_flag;
   endtask

   task automatic run_to_done(input string tag, input int limit);
      int d0;
      int k;
      d0 = n_done;
      k  = 0;
      while (n_done == d0 && k < limit) begin
         step();
         k++;
      end
      chk_eq({tag, "_done_seen"}, 64'(n_done != d0), 1);
      ap_start = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1; clk_en = 1; ap_start = 0; base = '0; btt = '0; core_done = 0;
      bus.cmd_ready = 1; bus.sts_valid = 0; bus.sts_okay = 1;
      credits = 0; bad_idx = -1; core_auto = 0; en_toggle = 0; last_st = '0;
      clear_counts();
      repeat (3) step();
      chk_eq("rst_idle", ap_idle, 1);
      chk_eq("rst_sts_ready", bus.sts_ready, 0);
      chk_eq("rst_cmd_valid", bus.cmd_valid, 0);
      chk_eq("rst_status", status, 0);
      chk_eq("rst_lat", lat, 0);
      rst = 0;
      step();

      // Scenario 1: 10000 bytes from 0x1000, all statuses ok
      clear_counts();
      credits = 100; core_auto = 1;
      base = 64'h1000; btt = 10000; ap_start = 1;
      run_to_done("s1", 100);
      repeat (2) step();
      chk_eq("s1_ncmd", cmd_q.size(), 3);
      if (cmd_q.size() == 3) begin
         chk_eq("s1_c0_addr", cmd_q[0].a, 64'h1000);
         chk_eq("s1_c0_btt_eof", {cmd_q[0].b, cmd_q[0].e}, {23'd4096, 1'b0});
         chk_eq("s1_c1_addr", cmd_q[1].a, 64'h2000);
         chk_eq("s1_c1_btt_eof", {cmd_q[1].b, cmd_q[1].e}, {23'd4096, 1'b0});
         chk_eq("s1_c2_addr", cmd_q[2].a, 64'h3000);
         chk_eq("s1_c2_btt_eof", {cmd_q[2].b, cmd_q[2].e}, {23'd1808, 1'b1});
      end
      chk_eq("s1_core_start", n_cs, 1);
      chk_eq("s1_ap_done", n_done, 1);
      chk_eq("s1_ap_ready", n_rdy, 1);
      chk_eq("s1_done_state", last_st, 3'd4);
      chk_eq("s1_status", status, 32'h0003_0000);

      // Scenario 2: zero-length stream, core_done in the core_start cycle
      clear_counts();
      core_auto = 0; btt = 0; base = 64'h8000; ap_start = 1;
      step();
      chk_eq("s2_ap_ready", n_rdy, 1);
      chk_eq("s2_core_start", core_start, 1);
      core_done = 1;
      step();
      chk_eq("s2_ap_done", ap_done, 1);
      core_done = 0; ap_start = 0;
      step();
      chk_eq("s2_idle", ap_idle, 1);
      chk_eq("s2_no_cmd_valid", n_cv, 0);
      chk_eq("s2_n_core_start", n_cs, 1);
      chk_eq("s2_lat", lat, LAT_EN ? 64'd2 : 64'd0);
      core_done = 1;
      step();
      core_done = 0;
      step();
      chk_eq("s2_stray_core_done_idle", ap_idle, 1);
      chk_eq("s2_stray_core_done_nodone", n_done, 1);

      // Scenario 3: statuses withheld, outstanding limit of 2
      clear_counts();
      credits = 0; core_auto = 1; base = 64'h0; btt = 16384; ap_start = 1;
      repeat (6) step();
      chk_eq("s3_pending_cmds", cmd_q.size(), 2);
      chk_eq("s3_outst_field", status[11:8], 4'd2);
      chk_eq("s3_valid_blocked", bus.cmd_valid, 0);
      credits = 1;
      step();
      chk_eq("s3_valid_in_sts_cycle", bus.cmd_valid, 0);
      step();
      chk_eq("s3_third_valid", bus.cmd_valid, 1);
      chk_eq("s3_third_addr", bus.cmd_addr, 64'h2000);
      credits = 100;
      run_to_done("s3", 100);
      chk_eq("s3_ncmd", cmd_q.size(), 4);
      if (cmd_q.size() == 4)
         chk_eq("s3_last_eof", {cmd_q[3].a, cmd_q[3].e}, {64'h3000, 1'b1});
      chk_eq("s3_core_start", n_cs, 1);

      // Scenario 4: second status fails
      clear_counts();
      credits = 100; bad_idx = 1; base = 64'h0; btt = 16384; ap_start = 1;
      run_to_done("s4", 100);
      repeat (3) step();
      chk_eq("s4_no_more_cmds", cmd_q.size(), 64'(n_cmd_at_err));
      chk_eq("s4_drained", pend, 0);
      chk_eq("s4_core_start", n_cs, 0);
      chk_eq("s4_ap_done", n_done, 1);
      chk_eq("s4_done_state", last_st, 3'd5);
      chk_eq("s4_err_readable", status[12], 1);
      chk_eq("s4_outst_zero", status[11:8], 0);
      bad_idx = -1;

      // Scenario 5: reset during RUN, then stalled and toggled clk_en
      clear_counts();
      credits = 100; core_auto = 0; base = 64'h0; btt = 4096; ap_start = 1;
      for (int k = 0; k < 50 && n_cs == 0; k++) step();
      chk_eq("s5_reached_run", n_cs, 1);
      rst = 1; ap_start = 0;
      step();
      rst = 0;
      chk_eq("s5_rst_idle", ap_idle, 1);
      chk_eq("s5_rst_sts_ready", bus.sts_ready, 0);
      chk_eq("s5_rst_status", status, 0);
      chk_eq("s5_rst_lat", lat, 0);
      chk_eq("s5_rst_core_start", core_start, 0);

      clear_counts();
      core_auto = 1; clk_en = 0; btt = 0; ap_start = 1;
      repeat (3) step();
      chk_eq("s5_stall_idle", ap_idle, 1);
      chk_eq("s5_stall_no_ready", n_rdy, 0);
      en_toggle = 1;
      run_to_done("s5a", 100);
      en_toggle = 0; clk_en = 1;
      step();
      chk_eq("s5a_lat", lat, LAT_EN ? 64'd3 : 64'd0);
      chk_eq("s5a_core_start", n_cs, 1);
      chk_eq("s5a_ap_ready", n_rdy, 1);

      clear_counts();
      bus.cmd_ready = 0; base = 64'hFFFF_FFFF_FFFF_F000; btt = 8192; ap_start = 1;
      repeat (3) step();
      chk_eq("s5b_hold_valid", bus.cmd_valid, 1);
      chk_eq("s5b_hold_addr", bus.cmd_addr, 64'hFFFF_FFFF_FFFF_F000);
      chk_eq("s5b_hold_btt", bus.cmd_btt, 23'd4096);
      bus.cmd_ready = 1; en_toggle = 1;
      run_to_done("s5b", 200);
      en_toggle = 0; clk_en = 1;
      step();
      chk_eq("s5b_ncmd", cmd_q.size(), 2);
      if (cmd_q.size() == 2) begin
         chk_eq("s5b_c0", {cmd_q[0].a, cmd_q[0].b, cmd_q[0].e},
                {64'hFFFF_FFFF_FFFF_F000, 23'd4096, 1'b0});
         chk_eq("s5b_c1_wrap", {cmd_q[1].a, cmd_q[1].b, cmd_q[1].e},
                {64'h0, 23'd4096, 1'b1});
      end
      chk_eq("s5b_chunks", status[31:16], 2);
      chk_eq("s5b_ap_done", n_done, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
